// File: rtl/reorder_buffer.sv
// Reorder buffer: up to three dispatches, three writebacks and three in-order retires per cycle.
// An excepting instruction retires alone from slot 0.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            freeze_front,
  input  logic [2:0]      valid_dis,
  input  logic [2:0][5:0] pd_old_dis,
  output logic [2:0][3:0] tag_dis,
  input  logic [2:0]      valid_wb,
  input  logic [2:0][3:0] tag_wb,
  input  logic [2:0]      excep_wb,
  output logic            full_ROB,
  output logic [2:0]      ready_ret,
  output logic [2:0]      excep_ret,
  output logic [2:0][5:0] pd_old_ret
);

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DEPTH-1:0]      done_q, done_d;
  logic [DEPTH-1:0]      excep_q, excep_d;
  logic [DEPTH-1:0][5:0] pd_old_q, pd_old_d;
  logic [3:0]            head_q, head_d;
  logic [3:0]            tail_q, tail_d;
  logic [4:0]            count_q, count_d;

  logic [2:0][3:0] ret_idx;
  logic [2:0]      ok;
  logic [1:0]      n_alloc;
  logic [1:0]      n_ret;
  logic            alloc_ok;

  function automatic logic [3:0] wrap(input logic [3:0] base, input logic [31:0] off);
    logic [31:0] s;
    s = 32'(base) + off;
    return 4'(s % DEPTH);
  endfunction

  // full_ROB depends only on registered count, never on valid_dis.
  assign full_ROB = count_q > 5'(DEPTH - 3);
  assign alloc_ok = !freeze_front && !full_ROB && !flush;

  always_comb begin
    n_alloc = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tag_dis[k] = wrap(tail_q, 32'(n_alloc));
      if (valid_dis[k]) n_alloc = n_alloc + 2'd1;
    end
  end

  // ok[k]: entry head+k is complete and clean, so younger slots may retire with it.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ret_idx[k]    = wrap(head_q, 32'(k));
      ok[k]         = busy_q[ret_idx[k]] && done_q[ret_idx[k]] && !excep_q[ret_idx[k]];
      pd_old_ret[k] = pd_old_q[ret_idx[k]];
    end
    ready_ret[0] = busy_q[ret_idx[0]] && done_q[ret_idx[0]];
    ready_ret[1] = ok[0] && ok[1];
    ready_ret[2] = ok[0] && ok[1] && ok[2];
    for (int k = 0; k < 3; k++) begin
      excep_ret[k] = ready_ret[k] && excep_q[ret_idx[k]];
    end
    n_ret = 2'(ready_ret[0]) + 2'(ready_ret[1]) + 2'(ready_ret[2]);
  end

  always_comb begin
    busy_d   = busy_q;
    done_d   = done_q;
    excep_d  = excep_q;
    pd_old_d = pd_old_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    for (int k = 0; k < 3; k++) begin
      if (valid_wb[k] && busy_q[tag_wb[k]]) begin
        done_d[tag_wb[k]]  = 1'b1;
        excep_d[tag_wb[k]] = excep_wb[k];
      end
    end

    for (int k = 0; k < 3; k++) begin
      if (ready_ret[k]) begin
        busy_d[ret_idx[k]]  = 1'b0;
        done_d[ret_idx[k]]  = 1'b0;
        excep_d[ret_idx[k]] = 1'b0;
      end
    end
    head_d = wrap(head_q, 32'(n_ret));

    if (alloc_ok) begin
      for (int k = 0; k < 3; k++) begin
        if (valid_dis[k]) begin
          busy_d[tag_dis[k]]   = 1'b1;
          done_d[tag_dis[k]]   = 1'b0;
          excep_d[tag_dis[k]]  = 1'b0;
          pd_old_d[tag_dis[k]] = pd_old_dis[k];
        end
      end
      tail_d  = wrap(tail_q, 32'(n_alloc));
      count_d = count_q + 5'(n_alloc) - 5'(n_ret);
    end else begin
      count_d = count_q - 5'(n_ret);
    end

    if (flush) begin
      busy_d  = '0;
      done_d  = '0;
      excep_d = '0;
      head_d  = 4'd0;
      tail_d  = 4'd0;
      count_d = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      done_q   <= '0;
      excep_q  <= '0;
      pd_old_q <= '0;
      head_q   <= 4'd0;
      tail_q   <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      excep_q  <= excep_d;
      pd_old_q <= pd_old_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, writeback, in-order retire, full, wrap, flush, reset.
module tb_reorder_buffer;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            freeze_front;
  logic [2:0]      valid_dis;
  logic [2:0][5:0] pd_old_dis;
  logic [2:0][3:0] tag_dis;
  logic [2:0]      valid_wb;
  logic [2:0][3:0] tag_wb;
  logic [2:0]      excep_wb;
  logic            full_ROB;
  logic [2:0]      ready_ret;
  logic [2:0]      excep_ret;
  logic [2:0][5:0] pd_old_ret;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  reorder_buffer #(.DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .freeze_front (freeze_front),
    .valid_dis    (valid_dis),
    .pd_old_dis   (pd_old_dis),
    .tag_dis      (tag_dis),
    .valid_wb     (valid_wb),
    .tag_wb       (tag_wb),
    .excep_wb     (excep_wb),
    .full_ROB     (full_ROB),
    .ready_ret    (ready_ret),
    .excep_ret    (excep_ret),
    .pd_old_ret   (pd_old_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    freeze_front = 1'b0;
    valid_dis    = 3'b000;
    pd_old_dis   = '0;
    valid_wb     = 3'b000;
    tag_wb       = '0;
    excep_wb     = 3'b000;
  endtask

  task automatic dis(input logic [2:0] v, input logic [5:0] p0, input logic [5:0] p1,
                     input logic [5:0] p2);
    valid_dis     = v;
    pd_old_dis[0] = p0;
    pd_old_dis[1] = p1;
    pd_old_dis[2] = p2;
  endtask

  task automatic wb(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                    input logic [3:0] t2, input logic [2:0] e);
    valid_wb  = v;
    tag_wb[0] = t0;
    tag_wb[1] = t1;
    tag_wb[2] = t2;
    excep_wb  = e;
  endtask

  // Fill an empty ROB (head=tail=0) up to 14 entries: 4 x three, then two.
  task automatic fill14();
    for (int i = 0; i < 4; i++) begin
      dis(3'b111, 6'(3 * i), 6'(3 * i + 1), 6'(3 * i + 2));
      tick();
    end
    dis(3'b011, 6'd12, 6'd13, 6'd0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    chk("rst_full", 32'(full_ROB), 32'd0);
    chk("rst_ready", 32'(ready_ret), 32'd0);
    chk("rst_excep", 32'(excep_ret), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(dut.count_q), 32'd0);

    // Three dispatches from empty
    dis(3'b111, 6'd10, 6'd11, 6'd12);
    #1;
    chk("dis_tag0", 32'(tag_dis[0]), 32'd0);
    chk("dis_tag1", 32'(tag_dis[1]), 32'd1);
    chk("dis_tag2", 32'(tag_dis[2]), 32'd2);
    tick();
    idle();
    chk("dis_count", 32'(dut.count_q), 32'd3);
    chk("dis_tail", 32'(dut.tail_q), 32'd3);
    chk("dis_ready", 32'(ready_ret), 32'd0);

    // Clean writebacks retire all three together
    wb(3'b111, 4'd0, 4'd1, 4'd2, 3'b000);
    tick();
    idle();
    chk("wb_ready", 32'(ready_ret), 32'b111);
    chk("wb_excep", 32'(excep_ret), 32'd0);
    chk("wb_pd1", 32'(pd_old_ret[1]), 32'd11);
    tick();
    chk("ret_head", 32'(dut.head_q), 32'd3);
    chk("ret_count", 32'(dut.count_q), 32'd0);
    chk("ret_ready", 32'(ready_ret), 32'd0);

    // Exception in the middle retires alone from slot 0
    flush = 1'b1;
    tick();
    idle();
    chk("fl_head", 32'(dut.head_q), 32'd0);
    chk("fl_tail", 32'(dut.tail_q), 32'd0);
    dis(3'b111, 6'd20, 6'd21, 6'd22);
    tick();
    idle();
    wb(3'b111, 4'd0, 4'd1, 4'd2, 3'b010);
    tick();
    idle();
    chk("exc_ready", 32'(ready_ret), 32'b001);
    chk("exc_excep0", 32'(excep_ret), 32'b000);
    tick();
    chk("exc_head", 32'(dut.head_q), 32'd1);
    chk("exc_count", 32'(dut.count_q), 32'd2);
    chk("exc_ready1", 32'(ready_ret), 32'b001);
    chk("exc_excep1", 32'(excep_ret), 32'b001);
    chk("exc_pd", 32'(pd_old_ret[0]), 32'd21);
    flush = 1'b1;
    #1;
    chk("exc_ready_fl", 32'(ready_ret), 32'b001);
    tick();
    idle();
    chk("exc_fl_count", 32'(dut.count_q), 32'd0);
    chk("exc_fl_ready", 32'(ready_ret), 32'd0);

    // Full threshold
    fill14();
    chk("full_count", 32'(dut.count_q), 32'd14);
    chk("full_flag", 32'(full_ROB), 32'd1);
    chk("full_tail", 32'(dut.tail_q), 32'd14);
    dis(3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    idle();
    chk("full_tail_hold", 32'(dut.tail_q), 32'd14);
    chk("full_count_hold", 32'(dut.count_q), 32'd14);
    wb(3'b001, 4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    idle();
    chk("full_ret_ready", 32'(ready_ret), 32'b001);
    tick();
    chk("full_ret_count", 32'(dut.count_q), 32'd13);
    chk("full_ret_flag", 32'(full_ROB), 32'd0);

    // Drain to head=14, then wrap through 15 -> 0
    flush = 1'b1;
    tick();
    idle();
    fill14();
    for (int i = 0; i < 4; i++) begin
      wb(3'b111, 4'(3 * i), 4'(3 * i + 1), 4'(3 * i + 2), 3'b000);
      tick();
    end
    wb(3'b011, 4'd12, 4'd13, 4'd0, 3'b000);
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_head0", 32'(dut.head_q), 32'd14);
    chk("wrap_count0", 32'(dut.count_q), 32'd0);
    dis(3'b111, 6'd40, 6'd41, 6'd42);
    #1;
    chk("wrap_tag0", 32'(tag_dis[0]), 32'd14);
    chk("wrap_tag1", 32'(tag_dis[1]), 32'd15);
    chk("wrap_tag2", 32'(tag_dis[2]), 32'd0);
    tick();
    dis(3'b011, 6'd43, 6'd44, 6'd0);
    #1;
    chk("wrap_tag3", 32'(tag_dis[0]), 32'd1);
    chk("wrap_tag4", 32'(tag_dis[1]), 32'd2);
    tick();
    idle();
    chk("wrap_count", 32'(dut.count_q), 32'd5);
    chk("wrap_tail", 32'(dut.tail_q), 32'd3);
    wb(3'b111, 4'd14, 4'd15, 4'd0, 3'b000);
    tick();
    idle();
    chk("wrap_ready", 32'(ready_ret), 32'b111);
    chk("wrap_pd1", 32'(pd_old_ret[1]), 32'd41);
    tick();
    chk("wrap_head", 32'(dut.head_q), 32'd1);
    chk("wrap_count2", 32'(dut.count_q), 32'd2);

    // Flush beats same-cycle dispatch and writeback
    flush = 1'b1;
    dis(3'b111, 6'd50, 6'd51, 6'd52);
    wb(3'b111, 4'd1, 4'd2, 4'd3, 3'b000);
    tick();
    idle();
    chk("flx_count", 32'(dut.count_q), 32'd0);
    chk("flx_head", 32'(dut.head_q), 32'd0);
    chk("flx_tail", 32'(dut.tail_q), 32'd0);
    chk("flx_ready", 32'(ready_ret), 32'd0);

    // Writeback to a free entry is dropped; invalid slots do not consume tags
    wb(3'b001, 4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    idle();
    dis(3'b101, 6'd60, 6'd0, 6'd61);
    #1;
    chk("skip_tag0", 32'(tag_dis[0]), 32'd0);
    chk("skip_tag2", 32'(tag_dis[2]), 32'd1);
    tick();
    idle();
    chk("skip_ready", 32'(ready_ret), 32'd0);
    chk("skip_count", 32'(dut.count_q), 32'd2);
    freeze_front = 1'b1;
    dis(3'b111, 6'd1, 6'd2, 6'd3);
    tick();
    idle();
    chk("frz_tail", 32'(dut.tail_q), 32'd2);
    chk("frz_count", 32'(dut.count_q), 32'd2);
    wb(3'b011, 4'd0, 4'd1, 4'd0, 3'b000);
    tick();
    idle();
    chk("skip_ready2", 32'(ready_ret), 32'b011);
    chk("skip_pd1", 32'(pd_old_ret[1]), 32'd61);

    // Asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(ready_ret), 32'd0);
    chk("arst_count", 32'(dut.count_q), 32'd0);
    tick();
    rst = 1'b0;
    dis(3'b111, 6'd7, 6'd8, 6'd9);
    #1;
    chk("arst_tag2", 32'(tag_dis[2]), 32'd2);
    tick();
    idle();
    chk("arst_cnt3", 32'(dut.count_q), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
